// File: rtl/spi_reader_pkg.sv
// Shared types and frame geometry for the SPI register reader.
package spi_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  localparam int SPI_ADDR_W     = 8;
  localparam int SPI_DATA_W     = 32;
  localparam int SPI_FRAME_BITS = 40;
  localparam int SPI_BIT_CNT_W  = 6;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: CLK_DIV clk cycles per half-period, held low and cleared while disabled.
module spi_sclk_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise_stb,
  output logic o_fall_stb
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] r_cnt;
  logic             r_sclk;
  logic             w_term;

  // Strobes flag the clk edge on which r_sclk is about to toggle.
  assign w_term     = i_en && (r_cnt == DIV_W'(CLK_DIV - 1));
  assign o_rise_stb = w_term & ~r_sclk;
  assign o_fall_stb = w_term & r_sclk;
  assign o_sclk     = r_sclk;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_term) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_reg_reader.sv
// SPI mode-0 master: sends an 8-bit register address, then clocks in a 32-bit word.
module spi_reg_reader
  import spi_reader_pkg::*;
#(
  parameter int CLK_DIV  = 25,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [SPI_ADDR_W-1:0] i_addr,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [SPI_DATA_W-1:0] o_rdata,
  output logic                  o_spi_clk,
  output logic                  o_spi_cs,
  output logic                  o_spi_mosi,
  input  logic                  i_spi_miso
);

  localparam int WAIT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [SPI_BIT_CNT_W-1:0] LAST_BIT  = SPI_BIT_CNT_W'(SPI_FRAME_BITS - 1);
  localparam logic [SPI_BIT_CNT_W-1:0] DATA_BIT0 = SPI_BIT_CNT_W'(SPI_ADDR_W);

  state_t                   r_state, w_state_nxt;
  logic [WAIT_W-1:0]        r_wait, w_wait_nxt;
  logic [SPI_BIT_CNT_W-1:0] r_bit, w_bit_nxt;
  logic [SPI_ADDR_W-1:0]    r_addr, w_addr_nxt;
  logic [SPI_DATA_W-1:0]    r_shift, w_shift_nxt;
  logic [SPI_DATA_W-1:0]    r_rdata, w_rdata_nxt;
  logic                     r_cs, w_cs_nxt;
  logic                     r_mosi, w_mosi_nxt;
  logic                     r_busy, w_busy_nxt;
  logic                     r_done, w_done_nxt;
  logic                     r_sync1, r_sync2;
  logic                     w_sclk_en;
  logic                     w_fall;
  logic                     w_unused_rise;

  assign w_sclk_en = (r_state == SHIFT);

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_en       (w_sclk_en),
    .o_sclk     (o_spi_clk),
    .o_rise_stb (w_unused_rise),
    .o_fall_stb (w_fall)
  );

  // MISO is asynchronous; the two-stage delay is absorbed by capturing on the SCLK fall.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_spi_miso;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_wait  <= '0;
      r_bit   <= '0;
      r_addr  <= '0;
      r_shift <= '0;
      r_rdata <= '0;
      r_cs    <= 1'b1;
      r_mosi  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      r_bit   <= w_bit_nxt;
      r_addr  <= w_addr_nxt;
      r_shift <= w_shift_nxt;
      r_rdata <= w_rdata_nxt;
      r_cs    <= w_cs_nxt;
      r_mosi  <= w_mosi_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_bit_nxt   = r_bit;
    w_addr_nxt  = r_addr;
    w_shift_nxt = r_shift;
    w_rdata_nxt = r_rdata;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        w_wait_nxt = '0;
        w_bit_nxt  = '0;
        if (i_start) begin
          w_addr_nxt  = i_addr;
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (r_wait == WAIT_W'(CS_SETUP - 1)) begin
          w_wait_nxt  = '0;
          w_state_nxt = SHIFT;
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
      end
      SHIFT: begin
        // Address shifts out MSB-first and leaves zeros behind for the data phase.
        if (w_fall) begin
          w_addr_nxt = {r_addr[SPI_ADDR_W-2:0], 1'b0};
          if (r_bit >= DATA_BIT0) begin
            w_shift_nxt = {r_shift[SPI_DATA_W-2:0], r_sync2};
          end
          if (r_bit == LAST_BIT) begin
            w_state_nxt = HOLD;
          end else begin
            w_bit_nxt = r_bit + SPI_BIT_CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (r_wait == WAIT_W'(CS_HOLD - 1)) begin
          w_wait_nxt  = '0;
          w_state_nxt = GAP;
          w_rdata_nxt = r_shift;
          w_done_nxt  = 1'b1;
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
      end
      GAP: begin
        if (r_wait == WAIT_W'(CS_HOLD - 1)) begin
          w_wait_nxt  = '0;
          w_state_nxt = IDLE;
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_cs_nxt   = !((w_state_nxt == SETUP) || (w_state_nxt == SHIFT) || (w_state_nxt == HOLD));
    w_busy_nxt = (w_state_nxt != IDLE);
    w_mosi_nxt = ((w_state_nxt == SETUP) || (w_state_nxt == SHIFT)) ? w_addr_nxt[SPI_ADDR_W-1] : 1'b0;
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_rdata    = r_rdata;
  assign o_spi_cs   = r_cs;
  assign o_spi_mosi = r_mosi;

endmodule

// File: tb/tb_spi_reg_reader.sv
// Bench for spi_reg_reader: slave model, frame monitor and scoreboard for two parameter sets.
module tb_spi_reg_reader;

  logic        clk = 1'b0;
  logic [1:0]  rst = 2'b11;
  logic [1:0]  start = 2'b00;
  logic [7:0]  addr [2];
  logic [1:0]  busy, done, sclk, cs, mosi;
  logic [1:0]  miso = 2'b00;
  logic [31:0] rdata [2];

  always #5 clk = ~clk;

  spi_reg_reader dut0 (
    .i_clk (clk), .i_reset (rst[0]), .i_start (start[0]), .i_addr (addr[0]),
    .o_busy (busy[0]), .o_done (done[0]), .o_rdata (rdata[0]), .o_spi_clk (sclk[0]),
    .o_spi_cs (cs[0]), .o_spi_mosi (mosi[0]), .i_spi_miso (miso[0])
  );

  spi_reg_reader #(.CLK_DIV (3), .CS_SETUP (1), .CS_HOLD (1)) dut1 (
    .i_clk (clk), .i_reset (rst[1]), .i_start (start[1]), .i_addr (addr[1]),
    .o_busy (busy[1]), .o_done (done[1]), .o_rdata (rdata[1]), .o_spi_clk (sclk[1]),
    .o_spi_cs (cs[1]), .o_spi_mosi (mosi[1]), .i_spi_miso (miso[1])
  );

  function automatic logic [31:0] slave_word(input logic [7:0] a);
    case (a)
      8'h00:   return 32'h0000_0001;
      8'h04:   return 32'hDEAD_BEEF;
      8'h08:   return 32'h8000_000F;
      8'h10:   return 32'hA5A5_A5A5;
      default: return {24'h5A5A5A, a};
    endcase
  endfunction

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Event logs, written only by the monitor and read by the main sequence.
  int         na [2], nb [2], nd [2], nf [2];
  int         acc_lbl [2][32], bf_lbl [2][32], done_lbl [2][32];
  logic       acc_cs [2][32];
  logic [31:0] done_dat [2][32];
  logic [7:0] fr_addr [2][32];
  int         fr_rises [2][32], fr_mbad [2][32], fr_gap [2][32];
  int         rises [2], mbad [2], s_cnt [2], gap_run [2], sclk_bad [2];
  logic [7:0] s_addr [2];
  logic [1:0] p_busy = 2'b00, p_cs = 2'b11, p_sclk = 2'b00;

  initial forever begin
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      logic [31:0] w;
      if (busy[c] && !p_busy[c]) begin
        acc_lbl[c][na[c]] = cyc;
        acc_cs[c][na[c]]  = cs[c];
        na[c]++;
      end
      if (!busy[c] && p_busy[c]) begin
        bf_lbl[c][nb[c]] = cyc + 1;
        nb[c]++;
      end
      if (done[c]) begin
        done_lbl[c][nd[c]] = cyc + 1;
        done_dat[c][nd[c]] = rdata[c];
        nd[c]++;
      end
      if ((cs[c] != p_cs[c]) && sclk[c]) sclk_bad[c]++;
      if (cs[c]) begin
        if (!p_cs[c]) begin
          fr_addr[c][nf[c]]  = s_addr[c];
          fr_rises[c][nf[c]] = rises[c];
          fr_mbad[c][nf[c]]  = mbad[c];
          nf[c]++;
        end
        gap_run[c]++;
        s_cnt[c] = 0;
        rises[c] = 0;
        mbad[c]  = 0;
        miso[c]  = 1'b0;
      end else begin
        if (p_cs[c]) begin
          fr_gap[c][nf[c]] = gap_run[c];
          gap_run[c] = 0;
        end
        if (sclk[c] && !p_sclk[c]) begin
          rises[c]++;
          if (s_cnt[c] < 8) s_addr[c] = {s_addr[c][6:0], mosi[c]};
          else if (mosi[c]) mbad[c]++;
          s_cnt[c]++;
        end
        if (!sclk[c] && p_sclk[c]) begin
          w = slave_word(s_addr[c]);
          miso[c] = (s_cnt[c] >= 8 && s_cnt[c] < 40) ? w[39 - s_cnt[c]] : 1'b0;
        end
      end
      p_busy[c] = busy[c];
      p_cs[c]   = cs[c];
      p_sclk[c] = sclk[c];
    end
  end

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] sb [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int count(input int c, input int kind);
    case (kind)
      0:       return na[c];
      1:       return nb[c];
      2:       return nd[c];
      3:       return nf[c];
      default: return rises[c];
    endcase
  endfunction

  task automatic wait_for(input string tag, input int c, input int kind, input int target, input int budget);
    int i = 0;
    while (count(c, kind) < target && i < budget) begin
      tick();
      i++;
    end
    check({tag, " reached"}, 64'(count(c, kind) >= target), 64'd1);
  endtask

  task automatic do_read(input string tag, input int c, input logic [7:0] a, input logic [31:0] expd,
                         input int lat, input int blat);
    int k = na[c];
    int d = nd[c];
    int f = nf[c];
    int b = nb[c];
    addr[c]  = a;
    start[c] = 1'b1;
    sb.push_back(expd);
    tick();
    start[c] = 1'b0;
    addr[c]  = ~a;
    wait_for({tag, " accept"}, c, 0, k + 1, 10);
    wait_for({tag, " done"}, c, 2, d + 1, 2500);
    check({tag, " rdata"}, 64'(done_dat[c][d]), 64'(sb.pop_front()));
    check({tag, " done latency"}, 64'(done_lbl[c][d] - acc_lbl[c][k]), 64'(lat));
    check({tag, " cs low after accept"}, 64'(acc_cs[c][k]), 64'd0);
    wait_for({tag, " busy fall"}, c, 1, b + 1, 100);
    check({tag, " busy latency"}, 64'(bf_lbl[c][b] - acc_lbl[c][k]), 64'(blat));
    check({tag, " slave addr"}, 64'(fr_addr[c][f]), 64'(a));
    check({tag, " sclk rises"}, 64'(fr_rises[c][f]), 64'd40);
    check({tag, " mosi data zero"}, 64'(fr_mbad[c][f]), 64'd0);
  endtask

  initial begin
    int k, d, f;
    addr[0] = 8'h00;
    addr[1] = 8'h00;
    tick();
    tick();
    check("reset cs", 64'(cs[0]), 64'd1);
    check("reset sclk", 64'(sclk[0]), 64'd0);
    check("reset mosi", 64'(mosi[0]), 64'd0);
    check("reset busy", 64'(busy[0]), 64'd0);
    check("reset done", 64'(done[0]), 64'd0);
    check("reset rdata", 64'(rdata[0]), 64'd0);
    rst = 2'b00;
    tick();

    do_read("rd04", 0, 8'h04, 32'hDEADBEEF, 2009, 2013);

    // Back-to-back with start held high.
    k = na[0];
    d = nd[0];
    f = nf[0];
    addr[0]  = 8'h00;
    start[0] = 1'b1;
    sb.push_back(32'h0000_0001);
    wait_for("b2b accept1", 0, 0, k + 1, 10);
    addr[0] = 8'h08;
    sb.push_back(32'h8000_000F);
    wait_for("b2b accept2", 0, 0, k + 2, 2500);
    start[0] = 1'b0;
    wait_for("b2b done", 0, 2, d + 2, 2500);
    check("b2b rdata1", 64'(done_dat[0][d]), 64'(sb.pop_front()));
    check("b2b rdata2", 64'(done_dat[0][d + 1]), 64'(sb.pop_front()));
    repeat (100) tick();
    check("b2b done count", 64'(nd[0] - d), 64'd2);
    check("b2b accept count", 64'(na[0] - k), 64'd2);
    check("b2b cs gap>=4", 64'(fr_gap[0][f + 1] >= 4), 64'd1);
    check("b2b rises1", 64'(fr_rises[0][f]), 64'd40);
    check("b2b rises2", 64'(fr_rises[0][f + 1]), 64'd40);
    check("b2b addr2", 64'(fr_addr[0][f + 1]), 64'h08);

    // Start toggling while the frame is shifting.
    k = na[0];
    d = nd[0];
    f = nf[0];
    addr[0]  = 8'h04;
    start[0] = 1'b1;
    sb.push_back(32'hDEADBEEF);
    tick();
    start[0] = 1'b0;
    repeat (400) tick();
    for (int i = 0; i < 6; i++) begin
      start[0] = ~start[0];
      addr[0]  = 8'h08;
      repeat (3) tick();
    end
    start[0] = 1'b0;
    wait_for("tog done", 0, 2, d + 1, 2500);
    check("tog rdata", 64'(done_dat[0][d]), 64'(sb.pop_front()));
    check("tog slave addr", 64'(fr_addr[0][f]), 64'h04);
    repeat (100) tick();
    check("tog done count", 64'(nd[0] - d), 64'd1);
    check("tog accept count", 64'(na[0] - k), 64'd1);

    // Reset in the middle of SCLK period 20.
    d = nd[0];
    addr[0]  = 8'h08;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_for("rst period20", 0, 4, 21, 2500);
    rst[0] = 1'b1;
    #1;
    check("rst cs", 64'(cs[0]), 64'd1);
    check("rst sclk", 64'(sclk[0]), 64'd0);
    check("rst busy", 64'(busy[0]), 64'd0);
    check("rst rdata", 64'(rdata[0]), 64'd0);
    check("rst done", 64'(done[0]), 64'd0);
    repeat (5) tick();
    rst[0] = 1'b0;
    repeat (3000) tick();
    check("rst no done", 64'(nd[0] - d), 64'd0);
    do_read("post-rst rd00", 0, 8'h00, 32'h0000_0001, 2009, 2013);

    do_read("fast rd10", 1, 8'h10, 32'hA5A5A5A5, 243, 244);

    check("sclk low at cs toggle 0", 64'(sclk_bad[0]), 64'd0);
    check("sclk low at cs toggle 1", 64'(sclk_bad[1]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_reg_reader.md
# spi_reg_reader

SPI master that reads one 32-bit register from a remote SPI slave per request: it sends an 8-bit register address, then clocks in a 32-bit data word. It sits on the controller side of the robot's FPGA-to-host register link. It serves as the initiator for the FPGA register-read slave, both in bench loopback and on boards where the FPGA polls a peripheral FPGA. The frame is fixed: CS low, 40 SCLK periods in mode 0 (8 address bits then 32 data bits, both MSB-first), CS high.

## Interface
- CLK_DIV, 25: clk cycles per SCLK half-period; legal range ≥3; 25 gives 1 MHz SCLK at 50 MHz.
- CS_SETUP, 4: clk cycles from CS falling to the first SCLK rising edge; ≥1.
- CS_HOLD, 4: clk cycles CS stays low after the last SCLK falling edge, and also the minimum CS-high gap; ≥1.
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request strobe; sampled only when busy=0.
- addr  in  8  register address; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until the end of the CS-high gap.
- done  out  1  one-cycle pulse; rdata valid from this cycle.
- rdata  out  32  last received word; holds until the next done.
- spi_clk  out  1  SCLK; idles low.
- spi_cs  out  1  chip select, active low; idles high.
- spi_mosi  out  1  address bits; 0 when not shifting the address.
- spi_miso  in  1  slave data; asynchronous to clk.

## Operation
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: cs=1, sclk=0, mosi=0. If start=1, latch addr and go to SETUP.
- SETUP: cs=0, sclk=0, mosi=addr[7]. After CS_SETUP cycles, go to SHIFT.
- SHIFT: 40 SCLK periods, bit index 0..39. Each period has CLK_DIV cycles with SCLK low, then CLK_DIV cycles with SCLK high.
  - MOSI updates on each falling edge: addr[6..0] for bits 1..7, then 0 for bits 8..39.
  - MISO passes through a 2-FF synchronizer. The synchronized value is captured in the clk cycle where SCLK goes high→low, which compensates for the synchronizer delay.
  - Captures for bits 8..39 shift into the shift register MSB-first. Captures for bits 0..7 are discarded.
  - After the 40th falling edge, go to HOLD.
- HOLD: cs=0, sclk=0, mosi=0 for CS_HOLD cycles, then go to GAP.
- GAP: cs=1 for CS_HOLD cycles; busy stays 1.
  - On the first GAP cycle, the shift register is copied to rdata and done=1.
  - After CS_HOLD cycles, go to IDLE.
- start while busy=1 is ignored; there is no queuing.
- Reset (any state, including mid-frame): immediately go to IDLE. cs=1, sclk=0, mosi=0, busy=0, done=0, rdata=0, and all counters and the synchronizer are cleared. The partial frame is discarded and no done is issued.

## Timing
- Start accepted at clk edge N. At N+1: busy=1 and cs=0.
- First SCLK rise: N+1+CS_SETUP+CLK_DIV.
- done: N+1+CS_SETUP+80·CLK_DIV+CS_HOLD. With defaults this is N+2009.
- busy falls, and the next start can be accepted, at done+CS_HOLD. Defaults: N+2013.
- All outputs are registered; no combinational path from spi_miso or start to any output.
- Divider counter width is clog2(CLK_DIV). Bit counter is 6 bits, saturating at 39. No wrap is permitted mid-frame.

## Structure
- Package spi_reader_pkg holds:
  - state enum (IDLE, SETUP, SHIFT, HOLD, GAP);
  - SPI_ADDR_W=8, SPI_DATA_W=32, SPI_FRAME_BITS=40.
- Sub-module spi_sclk_gen: CLK_DIV divider with an enable input. It outputs sclk plus single-cycle rise_stb and fall_stb strobes, and is held low and reset when not enabled.

## Test plan
- Bench slave model returns 32'hDEADBEEF for addr 8'h04. Pulse start with addr=8'h04 → MOSI shows 0000_0100 on bits 0..7 and then zeros; rdata=32'hDEADBEEF with done at N+2009; busy low at N+2013.
- Back-to-back reads of addr 8'h00 (returns 0x00000001) then addr 8'h08 (returns 0x8000000F), with start held high continuously → two frames separated by ≥4 cycles of CS high; rdata sequence is 0x00000001, 0x8000000F; done is exactly two pulses.
- Toggle start during SHIFT → no effect; addr latched at acceptance is unchanged, and exactly one done occurs.
- Assert reset at SCLK period 20 → same cycle: cs=1, sclk=0, busy=0, rdata=0, with no done. A new read afterwards returns the correct value.
- CLK_DIV=3, CS_SETUP=1, CS_HOLD=1: read 0xA5A5A5A5 → captured correctly; done at N+243.
- Check per frame: exactly 40 SCLK rising edges with CS low; SCLK low whenever CS toggles.
